difftest_endpoint_mc: RTL

Multi-core, fully synthesisable successor to the single-core simulation endpoint. It aggregates per-core exit codes and commit steps, enforces cycle and instruction limits, and merges per-core UART output through a round-robin arbiter into a buffered sink. It sequences end-of-run through a drain phase so trailing console output is not lost. It sits between the SoC difftest top IO and the testbench/FPGA host shim.

---
 rtl/difftest_endpoint_mc.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/difftest_endpoint_mc.sv
// Multi-core difftest endpoint: exit/limit tracking, run sequencing and a
// round-robin UART merge into a shared first-word-fall-through FIFO.
module difftest_endpoint_mc #(
  parameter int NUM_CORES       = 2,
  parameter int STEP_WIDTH      = 8,
  parameter int UART_FIFO_DEPTH = 16,
  parameter int CYCLE_WIDTH     = 64,
  parameter int DRAIN_TIMEOUT   = 256,
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [CYCLE_WIDTH-1:0]           max_cycles,
  input  logic [63:0]                      max_instrs,
  input  logic [NUM_CORES*64-1:0]          core_exit,
  input  logic [NUM_CORES*STEP_WIDTH-1:0]  core_step,
  input  logic [NUM_CORES-1:0]             uart_out_valid,
  input  logic [NUM_CORES*8-1:0]           uart_out_ch,
  output logic                             uart_sink_valid,
  output logic [7:0]                       uart_sink_ch,
  output logic [CW-1:0]                    uart_sink_core,
  input  logic                             uart_sink_ready,
  output logic [NUM_CORES-1:0]             uart_overflow,
  output logic [2:0]                       sim_state,
  output logic [63:0]                      sim_code,
  output logic                             perf_dump,
  output logic [CYCLE_WIDTH-1:0]           n_cycles,
  output logic [63:0]                      n_instrs
);

  localparam int AW = $clog2(UART_FIFO_DEPTH);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int EW = CW + 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_PASS    = 3'd3,
    S_FAIL    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t               state;
  state_t               pend;
  logic [NUM_CORES-1:0] good;
  logic [NUM_CORES-1:0] good_nxt;
  logic [DW-1:0]        drain_cnt;
  logic [63:0]          step_sum;
  logic [63:0]          instr_nxt;
  logic [63:0]          err_code;
  logic                 err_hit;
  logic                 all_good;
  logic                 instr_hit;
  logic                 cyc_hit;
  logic                 end_hit;

  logic [NUM_CORES-1:0] skid_v;
  logic [NUM_CORES-1:0] skid_pop;
  logic [7:0]           skid_ch [NUM_CORES];
  logic [CW-1:0]        rr;
  logic [CW-1:0]        gnt;
  logic [CW-1:0]        idx;
  logic                 gnt_v;
  logic                 push;
  logic                 pop;
  logic                 capture;
  logic                 drained;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [EW-1:0]        mem [UART_FIFO_DEPTH];
  logic [EW-1:0]        head;

  // Descending scan so the lowest-index erroring core sets err_code.
  always_comb begin
    step_sum = '0;
    err_hit  = 1'b0;
    err_code = '0;
    good_nxt = good;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      step_sum = step_sum + 64'(core_step[i*STEP_WIDTH +: STEP_WIDTH]);
      if (&core_exit[i*64 +: 64]) begin
        good_nxt[i] = 1'b1;
      end else if (!good[i] && |core_exit[i*64 +: 64]) begin
        err_hit  = 1'b1;
        err_code = core_exit[i*64 +: 64];
      end
    end
  end

  assign instr_nxt = n_instrs + step_sum;
  assign all_good  = &good_nxt;
  assign instr_hit = (max_instrs != '0) && (instr_nxt >= max_instrs);
  assign cyc_hit   = (max_cycles != '0) && (n_cycles >= max_cycles);
  assign end_hit   = err_hit | all_good | instr_hit | cyc_hit;

  assign sim_state = state;

  // On the ending cycle the counters keep the values the end test used:
  // this cycle's steps are counted, the cycle count is not advanced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pend      <= S_IDLE;
      good      <= '0;
      drain_cnt <= '0;
      sim_code  <= '0;
      perf_dump <= 1'b0;
      n_cycles  <= '0;
      n_instrs  <= '0;
    end else begin
      perf_dump <= 1'b0;
      case (state)
        S_IDLE: state <= S_RUN;
        S_RUN: begin
          n_instrs <= instr_nxt;
          good     <= good_nxt;
          if (end_hit) begin
            state     <= S_DRAIN;
            perf_dump <= 1'b1;
            drain_cnt <= '0;
            if (err_hit) begin
              pend     <= S_FAIL;
              sim_code <= err_code;
            end else if (all_good) begin
              pend     <= S_PASS;
              sim_code <= '1;
            end else if (instr_hit) begin
              pend     <= S_PASS;
              sim_code <= '0;
            end else begin
              pend     <= S_TIMEOUT;
              sim_code <= 64'(n_cycles);
            end
          end else begin
            n_cycles <= n_cycles + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drained || drain_cnt == DW'(DRAIN_TIMEOUT - 1)) begin
            state <= pend;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && uart_sink_ready;
  assign capture    = (state == S_RUN) || (state == S_DRAIN);
  assign drained    = fifo_empty && !(|skid_v);

  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = CW'((int'(rr) + k) % NUM_CORES);
      if (!gnt_v && skid_v[idx]) begin
        gnt_v = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign push = gnt_v && (!fifo_full || pop);

  always_comb begin
    skid_pop = '0;
    if (push) skid_pop[gnt] = 1'b1;
  end

  assign head            = mem[rd_ptr[AW-1:0]];
  assign uart_sink_valid = !fifo_empty;
  assign uart_sink_ch    = fifo_empty ? 8'h00 : head[7:0];
  assign uart_sink_core  = fifo_empty ? '0 : head[EW-1:8];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {gnt, skid_ch[gnt]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_v        <= '0;
      uart_overflow <= '0;
      rr            <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      for (int i = 0; i < NUM_CORES; i++) skid_ch[i] <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr     <= (gnt == CW'(NUM_CORES - 1)) ? '0 : gnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (capture && uart_out_valid[i] && (!skid_v[i] || skid_pop[i])) begin
          skid_v[i]  <= 1'b1;
          skid_ch[i] <= uart_out_ch[i*8 +: 8];
        end else begin
          if (skid_pop[i]) skid_v[i] <= 1'b0;
          if (capture && uart_out_valid[i]) uart_overflow[i] <= 1'b1;
        end
      end
    end
  end

endmodule
